// File: rtl/wb_trace_buffer_if.sv
// Trace stream from the writeback trace buffer to its consumer.
// The buffer drives head-entry fields and valid; the consumer drives ready.
interface wb_trace_buffer_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [4:0]  tr_rd;
    logic [31:0] tr_data;
    logic [15:0] tr_seq;

    modport master (
        output tr_valid,
        output tr_rd,
        output tr_data,
        output tr_seq,
        input  tr_ready
    );

    modport slave (
        input  tr_valid,
        input  tr_rd,
        input  tr_data,
        input  tr_seq,
        output tr_ready
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Captures CPU writeback events (rd, data, sequence number) into a FIFO
// and presents them on a valid/ready trace stream, with commit and drop counters.
module wb_trace_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_reg_write,
    input  logic [4:0]                 wb_rd,
    input  logic [31:0]                wb_data,
    input  logic                       enable,
    input  logic                       flush,
    wb_trace_buffer_if.master          tr,
    output logic [31:0]                commit_count,
    output logic [15:0]                drop_count,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 5 + 32 + 16;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [EW-1:0] head;

    logic capture;
    logic pop;
    logic push;
    logic drop;

    assign capture = enable && wb_reg_write && (wb_rd != 5'd0);
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);

    // Flush suppresses both sides of the FIFO for the cycle it is asserted.
    assign pop  = tr.tr_valid && tr.tr_ready && !flush;
    assign push = capture && (!full || pop) && !flush;
    assign drop = capture && full && !pop && !flush;

    assign head        = mem[rd_ptr];
    assign tr.tr_valid = !empty;
    assign tr.tr_rd    = empty ? 5'd0  : head[EW-1 -: 5];
    assign tr.tr_data  = empty ? 32'd0 : head[47:16];
    assign tr.tr_seq   = empty ? 16'd0 : head[15:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            commit_count <= '0;
            drop_count   <= '0;
        end else begin
            if (capture) begin
                commit_count <= commit_count + 32'd1;
            end
            if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                level      <= '0;
                drop_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    level <= level + LW'(1);
                end else if (pop && !push) begin
                    level <= level - LW'(1);
                end
                if (drop && (drop_count != 16'hFFFF)) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Storage needs no reset: the head fields are masked whenever empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wb_rd, wb_data, commit_count[15:0]};
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: vector table plus hand-written
// sequences for reset, fill/overflow, full push+pop and flush.
module tb_wb_trace_buffer;

    logic        clk;
    logic        reset;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        enable;
    logic        flush;
    logic [31:0] commit_count;
    logic [15:0] drop_count;
    logic        full;
    logic        empty;
    logic [4:0]  level;

    wb_trace_buffer_if tr_if ();

    wb_trace_buffer #(.DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .enable       (enable),
        .flush        (flush),
        .tr           (tr_if),
        .commit_count (commit_count),
        .drop_count   (drop_count),
        .full         (full),
        .empty        (empty),
        .level        (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [4:0] rd, input logic [31:0] data,
                         input logic en, input logic fl, input logic rdy);
        wb_reg_write    = wr;
        wb_rd           = rd;
        wb_data         = data;
        enable          = en;
        flush           = fl;
        tr_if.tr_ready  = rdy;
    endtask

    typedef struct packed {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        en;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [15:0] e_seq;
        logic [31:0] e_commit;
        logic [15:0] e_drop;
        logic [4:0]  e_level;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [4:0] rd_of(input int s);
        return 5'((s % 31) + 1);
    endfunction

    function automatic logic [31:0] data_of(input int s);
        return 32'hD000_0000 + 32'(s);
    endfunction

    int          cnt;
    logic [15:0] exp_seq [16];

    initial begin
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        //            wr   rd     data           en   fl   rdy   valid rd    data           seq    commit drop  level
        vecs[0] = '{1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 16'd0, 32'd1, 16'd0, 5'd1};
        vecs[1] = '{1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 16'd0, 32'd1, 16'd0, 5'd1};
        vecs[2] = '{1'b1, 5'd3, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 16'd0, 32'd1, 16'd0, 5'd1};
        vecs[3] = '{1'b1, 5'd7, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 16'd0, 32'd2, 16'd0, 5'd2};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'hAAAA_0001, 16'd1, 32'd2, 16'd0, 5'd1};
        vecs[5] = '{1'b1, 5'd9, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'hBBBB_0002, 16'd2, 32'd3, 16'd0, 5'd1};
        vecs[6] = '{1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         16'd0, 32'd3, 16'd0, 5'd0};
        vecs[7] = '{1'b0, 5'd4, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         16'd0, 32'd3, 16'd0, 5'd0};

        #2;
        chk("rst_valid",  {31'd0, tr_if.tr_valid}, 32'd0);
        chk("rst_empty",  {31'd0, empty}, 32'd1);
        chk("rst_full",   {31'd0, full}, 32'd0);
        chk("rst_commit", commit_count, 32'd0);
        chk("rst_level",  {27'd0, level}, 32'd0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].data, vecs[i].en, vecs[i].fl, vecs[i].rdy);
            tick();
            chk($sformatf("v%0d_valid", i),  {31'd0, tr_if.tr_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_rd", i),     {27'd0, tr_if.tr_rd}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_data", i),   tr_if.tr_data, vecs[i].e_data);
            chk($sformatf("v%0d_seq", i),    {16'd0, tr_if.tr_seq}, {16'd0, vecs[i].e_seq});
            chk($sformatf("v%0d_commit", i), commit_count, vecs[i].e_commit);
            chk($sformatf("v%0d_drop", i),   {16'd0, drop_count}, {16'd0, vecs[i].e_drop});
            chk($sformatf("v%0d_level", i),  {27'd0, level}, {27'd0, vecs[i].e_level});
            chk($sformatf("v%0d_empty", i),  {31'd0, empty}, {31'd0, (vecs[i].e_level == 5'd0)});
        end

        // Mid-stream reset at level 5, observed between clock edges.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(i + 1), 32'hF000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_level", {27'd0, level}, 32'd5);
        reset = 1'b0;
        #1;
        chk("mrst_valid",  {31'd0, tr_if.tr_valid}, 32'd0);
        chk("mrst_empty",  {31'd0, empty}, 32'd1);
        chk("mrst_full",   {31'd0, full}, 32'd0);
        chk("mrst_level",  {27'd0, level}, 32'd0);
        chk("mrst_rd",     {27'd0, tr_if.tr_rd}, 32'd0);
        chk("mrst_data",   tr_if.tr_data, 32'd0);
        chk("mrst_seq",    {16'd0, tr_if.tr_seq}, 32'd0);
        chk("mrst_commit", commit_count, 32'd0);
        chk("mrst_drop",   {16'd0, drop_count}, 32'd0);
        tick();
        reset = 1'b1;

        // Fill: 17 captures, the 17th dropped.
        for (int s = 0; s < 17; s++) begin
            drive(1'b1, rd_of(s), data_of(s), 1'b1, 1'b0, 1'b0);
            tick();
            if (s == 0) chk("first_seq_after_rst", {16'd0, tr_if.tr_seq}, 32'd0);
        end
        chk("fill_level",  {27'd0, level}, 32'd16);
        chk("fill_full",   {31'd0, full}, 32'd1);
        chk("fill_drop",   {16'd0, drop_count}, 32'd1);
        chk("fill_commit", commit_count, 32'd17);
        chk("fill_head",   {16'd0, tr_if.tr_seq}, 32'd0);

        // Two more drops (seq 17, 18), then capture while full with ready.
        for (int s = 17; s < 19; s++) begin
            drive(1'b1, rd_of(s), data_of(s), 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("drop3", {16'd0, drop_count}, 32'd3);
        drive(1'b1, rd_of(19), data_of(19), 1'b1, 1'b0, 1'b1);
        tick();
        chk("fullpp_level",  {27'd0, level}, 32'd16);
        chk("fullpp_drop",   {16'd0, drop_count}, 32'd3);
        chk("fullpp_commit", commit_count, 32'd20);
        chk("fullpp_head",   {16'd0, tr_if.tr_seq}, 32'd1);

        for (int k = 0; k < 15; k++) exp_seq[k] = 16'(k + 1);
        exp_seq[15] = 16'd19;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        cnt = 0;
        while (tr_if.tr_valid && cnt < 20) begin
            if (cnt < 16) begin
                chk($sformatf("drain%0d_seq", cnt),  {16'd0, tr_if.tr_seq}, {16'd0, exp_seq[cnt]});
                chk($sformatf("drain%0d_rd", cnt),   {27'd0, tr_if.tr_rd}, {27'd0, rd_of(int'(exp_seq[cnt]))});
                chk($sformatf("drain%0d_data", cnt), tr_if.tr_data, data_of(int'(exp_seq[cnt])));
            end
            tick();
            cnt++;
        end
        chk("drain_count", 32'(cnt), 32'd16);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_drop_kept", {16'd0, drop_count}, 32'd3);

        // Head stays stable while not ready.
        drive(1'b1, 5'd11, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d_data", i), tr_if.tr_data, 32'h0BAD_F00D);
            chk($sformatf("hold%0d_seq", i),  {16'd0, tr_if.tr_seq}, 32'd20);
        end

        // Bring level to 8 (commit 21 -> 28), then flush with a capture.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 5'd12, 32'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("pre_flush_level",  {27'd0, level}, 32'd8);
        chk("pre_flush_commit", commit_count, 32'd28);
        drive(1'b1, 5'd13, 32'h1111_2222, 1'b1, 1'b1, 1'b1);
        tick();
        chk("flush_level",  {27'd0, level}, 32'd0);
        chk("flush_empty",  {31'd0, empty}, 32'd1);
        chk("flush_drop",   {16'd0, drop_count}, 32'd0);
        chk("flush_commit", commit_count, 32'd29);
        chk("flush_valid",  {31'd0, tr_if.tr_valid}, 32'd0);

        drive(1'b1, 5'd14, 32'h3333_4444, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_flush_seq",   {16'd0, tr_if.tr_seq}, 32'd29);
        chk("post_flush_data",  tr_if.tr_data, 32'h3333_4444);
        chk("post_flush_level", {27'd0, level}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: trace FIFO entries; power of 2, >= 2.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port wb_reg_write, input, 1: CPU writeback-stage register write enable.
REQ-005 SHALL have port wb_rd, input, 5: writeback destination register index.
REQ-006 SHALL have port wb_data, input, 32: writeback data.
REQ-007 SHALL have port enable, input, 1: capture enable.
REQ-008 SHALL have port flush, input, 1: synchronous FIFO clear.
REQ-009 SHALL have port tr_valid, output, 1: head entry available.
REQ-010 SHALL have port tr_ready, input, 1: consumer accepts head entry.
REQ-011 SHALL have port tr_rd, output, 5: head entry register index.
REQ-012 SHALL have port tr_data, output, 32: head entry data.
REQ-013 SHALL have port tr_seq, output, 16: head entry sequence number.
REQ-014 SHALL have port commit_count, output, 32: total captured writebacks.
REQ-015 SHALL have port drop_count, output, 16: writebacks lost to a full FIFO.
REQ-016 SHALL have port full, output, 1: level == DEPTH.
REQ-017 SHALL have port empty, output, 1: level == 0.
REQ-018 SHALL have port level, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-019 SHALL define the capture condition as enable && wb_reg_write && (wb_rd != 0); writes to x0 are never captured.
REQ-020 SHALL increment commit_count on every capture cycle, wrapping modulo 2^32, regardless of FIFO space or flush.
REQ-021 SHALL store each pushed entry as {wb_rd, wb_data, seq}, where seq = commit_count[15:0] before that cycle's increment.
REQ-022 SHALL pop when tr_valid && tr_ready; it SHALL push when capture && (!full || pop) && !flush.
REQ-023 SHALL count a drop on capture && full && !pop && !flush; drop_count saturates at 0xFFFF.
REQ-024 SHALL drive tr_valid = !empty; head fields come from FIFO storage with no input-to-output bypass. A capture at edge N is first visible after edge N.
REQ-025 SHALL hold tr_rd, tr_data and tr_seq stable while tr_valid && !tr_ready.
REQ-026 SHALL deliver entries in strict capture order; read and write pointers wrap modulo DEPTH.
REQ-027 SHALL leave level unchanged on a simultaneous push and pop, including when full and when level == 1.
REQ-028 SHALL, when flush is high, zero the pointers, level and drop_count at the edge, with no push or pop that cycle; commit_count is unaffected.
REQ-029 SHALL drive tr_rd, tr_data and tr_seq to 0 when empty.

Reset
REQ-030 SHALL, when reset is low, immediately clear the pointers, level, commit_count and drop_count, and drive tr_valid=0, empty=1, full=0 and data outputs=0, independent of clk.
REQ-031 SHALL discard FIFO contents on reset asserted mid-operation; the first capture after release gets seq=0.

Verification
REQ-032 Reset asserted mid-stream with FIFO at level 5 -> all outputs 0 and empty=1 without a clock edge.
REQ-033 Single capture rd=5, data=0x12345678 -> next cycle tr_valid=1, tr_rd=5, tr_data=0x12345678, tr_seq=0, commit_count=1, level=1.
REQ-034 wb_reg_write=1 with rd=0, or with enable=0 -> commit_count, level and drop_count unchanged.
REQ-035 17 consecutive captures with tr_ready=0 -> level=16, full=1, drop_count=1, commit_count=17; draining returns tr_seq 0..15 in order, then empty=1.
REQ-036 Full FIFO with capture and tr_ready=1 in the same cycle -> level stays 16, drop_count unchanged, new tail seq = previous commit_count[15:0].
REQ-037 flush=1 with capture at level 8, drop_count 3 -> next cycle level=0, empty=1, drop_count=0, commit_count incremented by 1.
